// File: rtl/sdram_pkg.sv
// ============================================================================
// Module   : sdram_pkg
// Brief    : Shared types and widths for the SDRAM arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package sdram_pkg;

    localparam int SDRAM_ADDR_W = 26;
    localparam int SDRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        CPU  = 2'd2,
        DONE = 2'd3
    } arb_state_t;

endpackage : sdram_pkg

`default_nettype wire

// File: rtl/sdram_arbiter_if.sv
// ============================================================================
// Module   : sdram_arbiter_if
// Brief    : Video, CPU and controller-side signals of the SDRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface sdram_arbiter_if
    import sdram_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W
);

    logic                    i_vid_req;
    logic [ADDR_W-1:0]       i_vid_address;
    logic                    o_vid_ready;
    logic [SDRAM_DATA_W-1:0] o_vid_data;

    logic                    i_cpu_req;
    logic                    i_cpu_we;
    logic [ADDR_W-1:0]       i_cpu_address;
    logic [SDRAM_DATA_W-1:0] i_cpu_data;
    logic                    o_cpu_ready;
    logic [SDRAM_DATA_W-1:0] o_cpu_data;

    logic                    o_mem_req;
    logic [ADDR_W-1:0]       o_mem_address;
    logic                    o_mem_we;
    logic [SDRAM_DATA_W-1:0] o_mem_data;
    logic [SDRAM_DATA_W-1:0] i_mem_data;
    logic                    i_mem_ready;

    // Arbiter side
    modport slave (
        input  i_vid_req, i_vid_address,
        output o_vid_ready, o_vid_data,
        input  i_cpu_req, i_cpu_we, i_cpu_address, i_cpu_data,
        output o_cpu_ready, o_cpu_data,
        output o_mem_req, o_mem_address, o_mem_we, o_mem_data,
        input  i_mem_data, i_mem_ready
    );

    // Requesters and controller side
    modport master (
        output i_vid_req, i_vid_address,
        input  o_vid_ready, o_vid_data,
        output i_cpu_req, i_cpu_we, i_cpu_address, i_cpu_data,
        input  o_cpu_ready, o_cpu_data,
        input  o_mem_req, o_mem_address, o_mem_we, o_mem_data,
        output i_mem_data, i_mem_ready
    );

endinterface : sdram_arbiter_if

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
// Module   : sdram_arbiter
// Brief    : Two-requester SDRAM port arbiter, video-priority with bounded
//            CPU starvation. One transaction in flight, all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W    = SDRAM_ADDR_W,
    parameter int VID_BURST = 8
) (
    input  logic           clock_100_mhz,
    input  logic           reset,
    sdram_arbiter_if.slave bus
);

    localparam logic [7:0] c_vid_burst = 8'(VID_BURST);

    arb_state_t              r_state;
    logic [7:0]              r_starve_cnt;
    logic                    r_mem_req;
    logic [ADDR_W-1:0]       r_mem_address;
    logic                    r_mem_we;
    logic [SDRAM_DATA_W-1:0] r_mem_data;
    logic                    r_vid_ready;
    logic [SDRAM_DATA_W-1:0] r_vid_data;
    logic                    r_cpu_ready;
    logic [SDRAM_DATA_W-1:0] r_cpu_data;

    logic w_grant_cpu;
    logic w_grant_vid;

    // CPU overrides video only when video is absent or has used its burst.
    always_comb begin
        w_grant_cpu = bus.i_cpu_req && (!bus.i_vid_req || (r_starve_cnt == c_vid_burst));
        w_grant_vid = bus.i_vid_req && !w_grant_cpu;
    end

    always_ff @(posedge clock_100_mhz) begin
        if (reset) begin
            r_state       <= IDLE;
            r_starve_cnt  <= '0;
            r_mem_req     <= 1'b0;
            r_mem_address <= '0;
            r_mem_we      <= 1'b0;
            r_mem_data    <= '0;
            r_vid_ready   <= 1'b0;
            r_vid_data    <= '0;
            r_cpu_ready   <= 1'b0;
            r_cpu_data    <= '0;
        end else begin
            r_vid_ready <= 1'b0;
            r_cpu_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_cpu) begin
                        r_mem_req     <= 1'b1;
                        r_mem_address <= bus.i_cpu_address;
                        r_mem_we      <= bus.i_cpu_we;
                        r_mem_data    <= bus.i_cpu_data;
                        r_starve_cnt  <= '0;
                        r_state       <= CPU;
                    end else if (w_grant_vid) begin
                        r_mem_req     <= 1'b1;
                        r_mem_address <= bus.i_vid_address;
                        r_mem_we      <= 1'b0;
                        r_mem_data    <= '0;
                        r_state       <= VID;
                        if (!bus.i_cpu_req) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt != c_vid_burst) begin
                            r_starve_cnt <= r_starve_cnt + 8'd1;
                        end
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                VID: begin
                    if (bus.i_mem_ready) begin
                        r_mem_req   <= 1'b0;
                        r_vid_data  <= bus.i_mem_data;
                        r_vid_ready <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                CPU: begin
                    if (bus.i_mem_ready) begin
                        r_mem_req   <= 1'b0;
                        r_cpu_ready <= 1'b1;
                        r_state     <= DONE;
                        if (!r_mem_we) begin
                            r_cpu_data <= bus.i_mem_data;
                        end
                    end
                end
                DONE: begin
                    // Gap cycle lets the requester drop its request.
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_mem_req     = r_mem_req;
    assign bus.o_mem_address = r_mem_address;
    assign bus.o_mem_we      = r_mem_we;
    assign bus.o_mem_data    = r_mem_data;
    assign bus.o_vid_ready   = r_vid_ready;
    assign bus.o_vid_data    = r_vid_data;
    assign bus.o_cpu_ready   = r_cpu_ready;
    assign bus.o_cpu_data    = r_cpu_data;

endmodule : sdram_arbiter

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// ============================================================================
// Module   : tb_sdram_arbiter
// Brief    : Directed self-checking bench for sdram_arbiter with a simple
//            variable-latency controller model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sdram_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;
    int   lat;
    int   wcnt;
    logic [7:0] mem [logic [25:0]];

    sdram_arbiter_if #(.ADDR_W(26)) bus ();

    sdram_arbiter #(.ADDR_W(26), .VID_BURST(8)) dut (
        .clock_100_mhz (clk),
        .reset         (reset),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input logic [25:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Controller model: ready in the lat-th request cycle, one cycle wide.
    initial begin
        bus.i_mem_ready = 1'b0;
        bus.i_mem_data  = 8'h00;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.i_mem_ready) begin
                bus.i_mem_ready = 1'b0;
                wcnt = 0;
            end else if (bus.o_mem_req) begin
                if (wcnt >= lat - 1) begin
                    bus.i_mem_ready = 1'b1;
                    if (bus.o_mem_we) begin
                        mem[bus.o_mem_address] = bus.o_mem_data;
                        bus.i_mem_data = 8'hEE;
                    end else if (mem.exists(bus.o_mem_address)) begin
                        bus.i_mem_data = mem[bus.o_mem_address];
                    end else begin
                        bus.i_mem_data = pat(bus.o_mem_address);
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic run_cpu(input bit we, input logic [25:0] addr, input logic [7:0] data,
                           output bit got_we, output logic [25:0] got_addr,
                           output logic [7:0] got_data, output bit unstable,
                           output int nready, output int gap, output bit timeout);
        bit seen;
        int m;
        seen = 0; unstable = 0; nready = 0; gap = -1; m = -1; timeout = 1;
        got_we = 0; got_addr = '0; got_data = '0;
        bus.i_cpu_we      = we;
        bus.i_cpu_address = addr;
        bus.i_cpu_data    = data;
        bus.i_cpu_req     = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.o_mem_req && !seen) begin
                seen = 1;
                got_we = bus.o_mem_we; got_addr = bus.o_mem_address; got_data = bus.o_mem_data;
            end else if (bus.o_mem_req) begin
                if (bus.o_mem_we !== got_we || bus.o_mem_address !== got_addr ||
                    bus.o_mem_data !== got_data) unstable = 1;
            end
            if (bus.o_cpu_ready) begin
                nready++;
                bus.i_cpu_req = 1'b0;
                if (gap < 0 && m >= 0) gap = cyc - m;
                timeout = 0;
            end
            if (bus.o_mem_req && bus.i_mem_ready) m = cyc;
        end
        bus.i_cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.i_vid_req = 0; bus.i_vid_address = '0;
        bus.i_cpu_req = 0; bus.i_cpu_we = 0; bus.i_cpu_address = '0; bus.i_cpu_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.o_mem_req, bus.o_mem_we, bus.o_vid_ready, bus.o_cpu_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.o_mem_req, bus.o_mem_we, bus.o_vid_ready, bus.o_cpu_ready});
        end
        checks++;
        if (bus.o_mem_address !== 26'h0 || bus.o_mem_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_mem_bus: got addr %h data %h expected 0/0", bus.o_mem_address, bus.o_mem_data);
        end
        checks++;
        if (bus.o_vid_data !== 8'h00 || bus.o_cpu_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got vid %h cpu %h expected 00/00", bus.o_vid_data, bus.o_cpu_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cpu_only();
        bit we, uns, to; logic [25:0] a; logic [7:0] d; int nr, gap;
        lat = 3;
        run_cpu(1'b1, 26'h0001234, 8'h5A, we, a, d, uns, nr, gap, to);
        checks++;
        if (we !== 1'b1 || a !== 26'h0001234 || d !== 8'h5A) begin
            failures++;
            $display("FAIL cpu_write_bus: got we %b addr %h data %h expected 1 0001234 5a", we, a, d);
        end
        checks++;
        if (nr !== 1 || to) begin
            failures++;
            $display("FAIL cpu_write_ready: got %0d pulses (timeout %0d) expected 1", nr, to);
        end
        run_cpu(1'b0, 26'h0001234, 8'h00, we, a, d, uns, nr, gap, to);
        checks++;
        if (we !== 1'b0 || a !== 26'h0001234) begin
            failures++;
            $display("FAIL cpu_read_bus: got we %b addr %h expected 0 0001234", we, a);
        end
        checks++;
        if (nr !== 1 || to) begin
            failures++;
            $display("FAIL cpu_read_ready: got %0d pulses (timeout %0d) expected 1", nr, to);
        end
        checks++;
        if (bus.o_cpu_data !== 8'h5A) begin
            failures++;
            $display("FAIL cpu_read_data: got %h expected 5a", bus.o_cpu_data);
        end
    endtask

    task automatic test_latency();
        bit we, uns, to; logic [25:0] a; logic [7:0] d; int nr, gap;
        int lats [2] = '{1, 10};
        for (int k = 0; k < 2; k++) begin
            lat = lats[k];
            run_cpu(1'b1, 26'h0000777, 8'h11, we, a, d, uns, nr, gap, to);
            checks++;
            if (uns) begin
                failures++;
                $display("FAIL latency_stable lat=%0d: got unstable=1 expected 0", lat);
            end
            checks++;
            if (gap !== 1 || nr !== 1) begin
                failures++;
                $display("FAIL latency_ready lat=%0d: got gap %0d pulses %0d expected 1/1", lat, gap, nr);
            end
        end
        checks++;
        if (bus.o_cpu_data !== 8'h5A) begin
            failures++;
            $display("FAIL write_keeps_cpu_data: got %h expected 5a", bus.o_cpu_data);
        end
    endtask

    task automatic test_simultaneous();
        logic [25:0] g_addr [4];
        int g_cyc [4];
        int ng, m_first;
        bit prev;
        logic [7:0] vdat;
        lat = 2; ng = 0; m_first = -1; prev = 0; vdat = 8'h00;
        @(negedge clk);
        bus.i_vid_address = 26'h0000100; bus.i_vid_req = 1'b1;
        bus.i_cpu_we = 1'b0; bus.i_cpu_address = 26'h0000200; bus.i_cpu_req = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.o_mem_req && !prev && ng < 4) begin
                g_addr[ng] = bus.o_mem_address; g_cyc[ng] = cyc; ng++;
            end
            prev = bus.o_mem_req;
            if (bus.o_vid_ready) begin bus.i_vid_req = 1'b0; vdat = bus.o_vid_data; end
            if (bus.o_cpu_ready) bus.i_cpu_req = 1'b0;
            if (bus.o_mem_req && bus.i_mem_ready && m_first < 0) m_first = cyc;
        end
        bus.i_vid_req = 1'b0; bus.i_cpu_req = 1'b0;
        checks++;
        if (ng !== 2) begin
            failures++;
            $display("FAIL simul_grants: got %0d expected 2", ng);
        end else begin
            checks++;
            if (g_addr[0] !== 26'h0000100 || g_addr[1] !== 26'h0000200) begin
                failures++;
                $display("FAIL simul_order: got %h,%h expected 0000100,0000200", g_addr[0], g_addr[1]);
            end
            checks++;
            if (g_cyc[1] - m_first !== 3) begin
                failures++;
                $display("FAIL simul_gap: got %0d expected 3", g_cyc[1] - m_first);
            end
        end
        checks++;
        if (vdat !== pat(26'h0000100) || bus.o_cpu_data !== pat(26'h0000200)) begin
            failures++;
            $display("FAIL simul_data: got vid %h cpu %h expected %h %h",
                     vdat, bus.o_cpu_data, pat(26'h0000100), pat(26'h0000200));
        end
    endtask

    task automatic test_back_to_back();
        byte owner [16];
        bit  vwe [16];
        int ng; bit prev;
        lat = 1; ng = 0; prev = 0;
        @(negedge clk);
        bus.i_vid_address = 26'h0000010; bus.i_vid_req = 1'b1;
        bus.i_cpu_we = 1'b0; bus.i_cpu_address = 26'h0003000; bus.i_cpu_req = 1'b1;
        for (int i = 0; i < 300 && ng < 12; i++) begin
            @(negedge clk);
            if (bus.o_mem_req && !prev) begin
                owner[ng] = (bus.o_mem_address == 26'h0003000) ? "C" : "V";
                vwe[ng] = bus.o_mem_we;
                ng++;
            end
            prev = bus.o_mem_req;
            if (bus.o_vid_ready) bus.i_vid_address = bus.i_vid_address + 26'd1;
            if (bus.o_cpu_ready) bus.i_cpu_req = 1'b0;
        end
        bus.i_vid_req = 1'b0; bus.i_cpu_req = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (ng !== 12) begin
            failures++;
            $display("FAIL burst_count: got %0d grants expected 12", ng);
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (owner[k] !== ((k == 8) ? 8'("C") : 8'("V"))) begin
                    failures++;
                    $display("FAIL burst_owner[%0d]: got %c expected %c", k, owner[k], (k == 8) ? "C" : "V");
                end
            end
            checks++;
            if (vwe[0] !== 1'b0 || vwe[9] !== 1'b0) begin
                failures++;
                $display("FAIL burst_vid_we: got %b%b expected 00", vwe[0], vwe[9]);
            end
        end
    endtask

    task automatic test_idle();
        int busy;
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_mem_req) busy++;
        end
        checks++;
        if (busy !== 0) begin
            failures++;
            $display("FAIL idle_mem_req: got %0d busy cycles expected 0", busy);
        end
        checks++;
        if (dut.r_starve_cnt !== 8'd0) begin
            failures++;
            $display("FAIL idle_starve_cnt: got %0d expected 0", dut.r_starve_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit seen; int stray;
        lat = 10; seen = 0; stray = 0;
        bus.i_cpu_we = 1'b1; bus.i_cpu_address = 26'h0000055; bus.i_cpu_data = 8'h77;
        bus.i_cpu_req = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_mem_req) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rmid_start: got no request expected o_mem_req=1");
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.o_mem_req, bus.o_mem_we, bus.o_vid_ready, bus.o_cpu_ready} !== 4'b0000 ||
            bus.o_mem_address !== 26'h0 || bus.o_mem_data !== 8'h00 ||
            bus.o_vid_data !== 8'h00 || bus.o_cpu_data !== 8'h00) begin
            failures++;
            $display("FAIL rmid_outputs: got req %b we %b addr %h data %h vd %h cd %h expected all 0",
                     bus.o_mem_req, bus.o_mem_we, bus.o_mem_address, bus.o_mem_data,
                     bus.o_vid_data, bus.o_cpu_data);
        end
        bus.i_cpu_req = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.o_cpu_ready || bus.o_mem_req) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL rmid_abandoned: got %0d ready/req cycles expected 0", stray);
        end
    endtask

    initial begin
        checks = 0; failures = 0; lat = 2;
        test_reset();
        test_cpu_only();
        test_latency();
        test_simultaneous();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sdram_arbiter

`default_nettype wire
